// File: rtl/tcdm_demux_pkg.sv
// Shared types and constants for the TCDM address demultiplexer.
package tcdm_demux_pkg;

  localparam int unsigned RULE_AW = 32;

  typedef struct packed {
    logic [RULE_AW-1:0] base;
    logic [RULE_AW-1:0] mask;
  } addr_rule_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hBADC_0FFE;

  // The internal error slave sits one past the last real target.
  function automatic int unsigned err_slave_idx(input int unsigned n_tgt);
    return n_tgt;
  endfunction

endpackage

// File: rtl/tcdm_demux_id_fifo.sv
// In-order queue of target indices for accepted-but-unanswered transactions.
// Zero-latency head; push is ignored when full, pop is ignored when empty.
module tcdm_demux_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2,
  localparam int unsigned CW   = $clog2(DEPTH+1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tcdm_addr_demux.sv
// Core data port to N_TGT targets via BASE/MASK decode plus an error slave; zero-latency
// request/response paths, error slave answers 1 cycle after accept; master held off when blocked.
module tcdm_addr_demux
  import tcdm_demux_pkg::*;
#(
  parameter int unsigned   N_TGT     = 3,
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   MAX_OUTST = 4,
  parameter logic [AW-1:0] TGT_BASE [N_TGT] = '{32'h1A10_0000, 32'h0000_0000, 32'h0000_0000},
  parameter logic [AW-1:0] TGT_MASK [N_TGT] = '{32'hFFF0_0000, 32'hFFFF_0000, 32'hFFF0_0000},
  parameter logic [DW-1:0] ERR_RDATA = ERR_RDATA_DEF,
  localparam int unsigned  BW = DW/8,
  localparam int unsigned  CW = $clog2(MAX_OUTST+1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mst_req_i,
  output logic                mst_gnt_o,
  input  logic [AW-1:0]       mst_add_i,
  input  logic                mst_wen_i,
  input  logic [BW-1:0]       mst_be_i,
  input  logic [DW-1:0]       mst_data_i,
  output logic [DW-1:0]       mst_r_data_o,
  output logic                mst_r_valid_o,
  output logic                mst_err_o,
  output logic [N_TGT-1:0]    tgt_req_o,
  output logic [N_TGT*AW-1:0] tgt_add_o,
  output logic [N_TGT-1:0]    tgt_wen_o,
  output logic [N_TGT*BW-1:0] tgt_be_o,
  output logic [N_TGT*DW-1:0] tgt_data_o,
  input  logic [N_TGT-1:0]    tgt_gnt_i,
  input  logic [N_TGT*DW-1:0] tgt_r_data_i,
  input  logic [N_TGT-1:0]    tgt_r_valid_i,
  output logic [CW-1:0]       outst_o,
  output logic                proto_err_o
);

  localparam int unsigned IW  = $clog2(N_TGT+1);
  localparam int unsigned ERR = err_slave_idx(N_TGT);

  addr_rule_t    rule [N_TGT];
  logic [IW-1:0] sel, last_sel, head;
  logic [CW-1:0] count;
  logic          issue_ok, accept, full, empty, err_q, rsp_vld, stray;
  logic [DW-1:0] rsp_dat;

  for (genvar g = 0; g < int'(N_TGT); g++) begin : g_rule
    assign rule[g] = '{base: TGT_BASE[g], mask: TGT_MASK[g]};
  end

  // Lowest matching rule wins, so scan from the top down.
  always_comb begin
    sel = IW'(ERR);
    for (int i = int'(N_TGT) - 1; i >= 0; i--)
      if ((mst_add_i & rule[i].mask) == rule[i].base) sel = IW'(i);
  end

  // Only one target may have transactions in flight, so responses cannot overtake.
  assign issue_ok = !rst_i && !full && (empty || sel == last_sel);

  always_comb begin
    mst_gnt_o = 1'b0;
    tgt_req_o = '0;
    if (issue_ok) begin
      if (sel == IW'(ERR)) mst_gnt_o = 1'b1;
      for (int i = 0; i < int'(N_TGT); i++) begin
        if (sel == IW'(i)) begin
          tgt_req_o[i] = mst_req_i;
          mst_gnt_o    = tgt_gnt_i[i];
        end
      end
    end
  end

  assign accept     = mst_req_i & mst_gnt_o;
  assign tgt_add_o  = {N_TGT{mst_add_i}};
  assign tgt_wen_o  = {N_TGT{mst_wen_i}};
  assign tgt_be_o   = {N_TGT{mst_be_i}};
  assign tgt_data_o = {N_TGT{mst_data_i}};

  // An error entry is always the head by the time err_q fires.
  always_comb begin
    rsp_vld = err_q;
    rsp_dat = err_q ? ERR_RDATA : '0;
    stray   = 1'b0;
    for (int i = 0; i < int'(N_TGT); i++) begin
      if (tgt_r_valid_i[i]) begin
        if (!empty && head == IW'(i)) begin
          rsp_vld = 1'b1;
          rsp_dat = tgt_r_data_i[i*DW +: DW];
        end else begin
          stray = 1'b1;
        end
      end
    end
  end

  assign mst_r_valid_o = rsp_vld;
  assign mst_r_data_o  = rsp_dat;
  assign mst_err_o     = err_q;
  assign outst_o       = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_sel    <= '0;
      err_q       <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      if (accept) last_sel <= sel;
      err_q <= accept && (sel == IW'(ERR));
      if (stray) proto_err_o <= 1'b1;
    end
  end

  tcdm_demux_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (IW)
  ) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (accept),
    .din   (sel),
    .pop   (rsp_vld),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule
